// File: rtl/cpu_pkg.sv
// Opcode and sequencer state encodings shared by the control unit files.
// CU_MULDIV_EN enables the mul/div execute sequences.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
    OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_DIV, OP_MUL,
    OP_NEG, OP_NOT, OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
    OP_NOP, OP_HALT
  } opcode_t;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT
  } state_t;

  typedef struct packed {
    logic       Run;
    logic       HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic       HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic       Gra, Grb, Grc, Rin, Rout, BAout;
    logic       Read, write, IncPC;
    logic [4:0] ALUop;
  } ctrl_t;

  // halt and the four unused codes above it all park the sequencer
  function automatic logic halts(input logic [4:0] op);
    return op >= 5'd27;
  endfunction

  // number of execute steps after DEC; zero means the instruction ends at DEC
  function automatic logic [2:0] exec_steps(input logic [4:0] op);
    case (op)
      OP_LD:                                  return 3'd6;
      OP_ST:                                  return 3'd5;
      OP_BR:                                  return 3'd4;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                         return 3'd4;
`endif
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:       return 3'd3;
      OP_NEG, OP_NOT, OP_JAL:                 return 3'd2;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return 3'd1;
      default:                                return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Sequencer-to-datapath control bundle: instruction/flag inputs and all strobes.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON, Stop, Run;
  logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, write, IncPC;
  logic [4:0]  ALUop;

  modport master (
    input  IR, CON, Stop,
    output Run, HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, ALUop
  );

  modport slave (
    output IR, CON, Stop,
    input  Run, HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, ALUop
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational decode of sequencer state (plus opcode and CON) into datapath strobes.
// mul/div execute strobes exist only when CU_MULDIV_EN is defined.
module cu_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con,
  output ctrl_t      ctrl
);

  logic [2:0] step;
  logic       imm;

  always_comb begin
    ctrl = '0;
    step = 3'(state - S_E0);
    imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    case (state)
      S_RST, S_HALT: ;
      S_F0: begin
        ctrl.Run = 1'b1; ctrl.PCout = 1'b1; ctrl.MARin = 1'b1;
        ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1; ctrl.ALUop = OP_ADD;
      end
      S_F1: begin
        ctrl.Run = 1'b1; ctrl.ALUop = opcode;
        ctrl.ZLOout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1;
      end
      S_F2: begin ctrl.Run = 1'b1; ctrl.ALUop = opcode; ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
      S_F3: begin ctrl.Run = 1'b1; ctrl.ALUop = opcode; ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
      S_DEC: begin ctrl.Run = 1'b1; ctrl.ALUop = opcode; end
      default: begin
        ctrl.Run   = 1'b1;
        ctrl.ALUop = opcode;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI:
            case (step)
              3'd0: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
              3'd1: begin
                ctrl.Zin = 1'b1;
                if (imm) ctrl.Cout = 1'b1;
                else begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; end
              end
              3'd2: begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
              default: ;
            endcase
          OP_NEG, OP_NOT:
            case (step)
              3'd0: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
              3'd1: begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
              default: ;
            endcase
          // ld, ldi and st share the effective-address steps E0-E1
          OP_LD, OP_LDI, OP_ST:
            case (step)
              3'd0: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
              3'd1: begin ctrl.Cout = 1'b1; ctrl.ALUop = OP_ADD; ctrl.Zin = 1'b1; end
              3'd2: begin
                ctrl.ZLOout = 1'b1;
                if (opcode == OP_LDI) begin ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                else ctrl.MARin = 1'b1;
              end
              3'd3: begin
                if (opcode == OP_ST) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
                else ctrl.Read = 1'b1;
              end
              3'd4: begin
                if (opcode == OP_ST) ctrl.write = 1'b1;
                else begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
              end
              3'd5: begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
              default: ;
            endcase
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV:
            case (step)
              3'd0: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
              3'd1: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
              3'd2: begin ctrl.ZLOout = 1'b1; ctrl.LOin = 1'b1; end
              3'd3: begin ctrl.ZHIout = 1'b1; ctrl.HIin = 1'b1; end
              default: ;
            endcase
`endif
          OP_BR:
            case (step)
              3'd0: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
              3'd1: begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
              3'd2: begin ctrl.Cout = 1'b1; ctrl.ALUop = OP_ADD; ctrl.Zin = 1'b1; end
              3'd3: begin ctrl.ZLOout = 1'b1; ctrl.PCin = con; end
              default: ;
            endcase
          OP_JR: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
          OP_JAL:
            case (step)
              3'd0: begin ctrl.PCout = 1'b1; ctrl.Grb = 1'b1; ctrl.Rin = 1'b1; end
              3'd1: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
              default: ;
            endcase
          OP_MFHI: begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
          OP_MFLO: begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
          OP_IN:   begin ctrl.INPORTout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
          OP_OUT:  begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OUTPORTin = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer: fetch, decode, per-opcode execute steps, HALT.
// Define CU_MULDIV_EN to run mul/div; otherwise they retire at DEC like nop.
module control_unit
  import cpu_pkg::*;
(
  input  logic          Clock,
  input  logic          clr,
  control_unit_if.master cu
);

  state_t     state, next_state;
  ctrl_t      ctrl;
  logic [4:0] opcode;
  logic [2:0] steps, cur_step;
  logic       ir_unused;

  assign opcode    = cu.IR[31:27];
  assign ir_unused = ^cu.IR[26:0];
  assign steps     = exec_steps(opcode);

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) state <= S_RST;
    else      state <= next_state;
  end

  // Stop is only honoured when the current step retires the instruction
  always_comb begin
    next_state = state;
    cur_step   = 3'(state - S_E0);
    case (state)
      S_RST:  next_state = S_F0;
      S_F0:   next_state = S_F1;
      S_F1:   next_state = S_F2;
      S_F2:   next_state = S_F3;
      S_F3:   next_state = S_DEC;
      S_DEC: begin
        if (halts(opcode))     next_state = S_HALT;
        else if (steps == '0)  next_state = cu.Stop ? S_HALT : S_F0;
        else                   next_state = S_E0;
      end
      S_HALT: next_state = S_HALT;
      default: begin
        if (3'(cur_step + 3'd1) == steps) next_state = cu.Stop ? S_HALT : S_F0;
        else                              next_state = state_t'(state + 4'd1);
      end
    endcase
  end

  cu_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .con    (cu.CON),
    .ctrl   (ctrl)
  );

  assign cu.Run       = ctrl.Run;
  assign cu.HIin      = ctrl.HIin;
  assign cu.LOin      = ctrl.LOin;
  assign cu.PCin      = ctrl.PCin;
  assign cu.MDRin     = ctrl.MDRin;
  assign cu.Zin       = ctrl.Zin;
  assign cu.Yin       = ctrl.Yin;
  assign cu.MARin     = ctrl.MARin;
  assign cu.IRin      = ctrl.IRin;
  assign cu.CONin     = ctrl.CONin;
  assign cu.OUTPORTin = ctrl.OUTPORTin;
  assign cu.HIout     = ctrl.HIout;
  assign cu.LOout     = ctrl.LOout;
  assign cu.ZHIout    = ctrl.ZHIout;
  assign cu.ZLOout    = ctrl.ZLOout;
  assign cu.PCout     = ctrl.PCout;
  assign cu.MDRout    = ctrl.MDRout;
  assign cu.INPORTout = ctrl.INPORTout;
  assign cu.Cout      = ctrl.Cout;
  assign cu.Gra       = ctrl.Gra;
  assign cu.Grb       = ctrl.Grb;
  assign cu.Grc       = ctrl.Grc;
  assign cu.Rin       = ctrl.Rin;
  assign cu.Rout      = ctrl.Rout;
  assign cu.BAout     = ctrl.BAout;
  assign cu.Read      = ctrl.Read;
  assign cu.write     = ctrl.write;
  assign cu.IncPC     = ctrl.IncPC;
  assign cu.ALUop     = ctrl.ALUop;

endmodule
